// File: rtl/alu_seq.sv
// Sequential RV32-style ALU: single-cycle ops complete in one cycle, while shifts
// iterate one bit per cycle through a small IDLE/SHIFT/DONE controller.
module alu_seq #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [3:0]       alu_op,
    input  logic [WIDTH-1:0] operand_a,
    input  logic [WIDTH-1:0] operand_b,
    input  logic [WIDTH-1:0] pc,
    output logic             ready,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             lt,
    output logic             ltu,
    output logic             err
);

    localparam int SHW = $clog2(WIDTH);

    localparam logic [3:0] OP_ADD   = 4'b0000;
    localparam logic [3:0] OP_SUB   = 4'b0001;
    localparam logic [3:0] OP_SLL   = 4'b0010;
    localparam logic [3:0] OP_SLT   = 4'b0011;
    localparam logic [3:0] OP_SLTU  = 4'b0100;
    localparam logic [3:0] OP_XOR   = 4'b0101;
    localparam logic [3:0] OP_SRL   = 4'b0110;
    localparam logic [3:0] OP_SRA   = 4'b0111;
    localparam logic [3:0] OP_OR    = 4'b1000;
    localparam logic [3:0] OP_AND   = 4'b1001;
    localparam logic [3:0] OP_LUI   = 4'b1010;
    localparam logic [3:0] OP_AUIPC = 4'b1011;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state_q;
    logic [3:0]       op_q;
    logic [WIDTH-1:0] sh_q;
    logic [SHW-1:0]   cnt_q;
    logic             ready_q;
    logic             done_q;
    logic             err_q;
    logic [WIDTH-1:0] result_q;
    logic             zero_q;
    logic             lt_q;
    logic             ltu_q;

    logic [SHW-1:0]   shamt_d;
    logic             is_shift_d;
    logic             lt_d;
    logic             ltu_d;
    logic [WIDTH-1:0] result_d;
    logic [WIDTH-1:0] step_d;

    // Shift ops return operand_a unchanged here; only the shamt=0 case uses this path.
    function automatic logic [WIDTH-1:0] alu_eval(
        input logic [3:0]       op,
        input logic [WIDTH-1:0] a,
        input logic [WIDTH-1:0] b,
        input logic [WIDTH-1:0] pcv
    );
        logic signed [WIDTH-1:0] a_s;
        logic signed [WIDTH-1:0] b_s;
        a_s = a;
        b_s = b;
        case (op)
            OP_ADD:   alu_eval = a + b;
            OP_SUB:   alu_eval = a - b;
            OP_SLL,
            OP_SRL,
            OP_SRA:   alu_eval = a;
            OP_SLT:   alu_eval = {{(WIDTH-1){1'b0}}, (a_s < b_s)};
            OP_SLTU:  alu_eval = {{(WIDTH-1){1'b0}}, (a < b)};
            OP_XOR:   alu_eval = a ^ b;
            OP_OR:    alu_eval = a | b;
            OP_AND:   alu_eval = a & b;
            OP_LUI:   alu_eval = b;
            OP_AUIPC: alu_eval = pcv + b;
            default:  alu_eval = '0;
        endcase
    endfunction

    function automatic logic op_undefined(input logic [3:0] op);
        op_undefined = (op > OP_AUIPC);
    endfunction

    function automatic logic [WIDTH-1:0] shift_one(
        input logic [3:0]       op,
        input logic [WIDTH-1:0] v
    );
        case (op)
            OP_SLL:  shift_one = {v[WIDTH-2:0], 1'b0};
            OP_SRA:  shift_one = {v[WIDTH-1], v[WIDTH-1:1]};
            default: shift_one = {1'b0, v[WIDTH-1:1]};
        endcase
    endfunction

    always_comb begin
        shamt_d    = operand_b[SHW-1:0];
        is_shift_d = (alu_op == OP_SLL) || (alu_op == OP_SRL) || (alu_op == OP_SRA);
        lt_d       = ($signed(operand_a) < $signed(operand_b));
        ltu_d      = (operand_a < operand_b);
        result_d   = alu_eval(alu_op, operand_a, operand_b, pc);
        step_d     = shift_one(op_q, sh_q);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            op_q     <= '0;
            sh_q     <= '0;
            cnt_q    <= '0;
            ready_q  <= 1'b1;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            result_q <= '0;
            zero_q   <= 1'b1;
            lt_q     <= 1'b0;
            ltu_q    <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        op_q    <= alu_op;
                        lt_q    <= lt_d;
                        ltu_q   <= ltu_d;
                        ready_q <= 1'b0;
                        if (is_shift_d && (shamt_d != '0)) begin
                            sh_q    <= operand_a;
                            cnt_q   <= shamt_d;
                            state_q <= SHIFT;
                        end else begin
                            result_q <= result_d;
                            zero_q   <= (result_d == '0);
                            err_q    <= op_undefined(alu_op);
                            done_q   <= 1'b1;
                            state_q  <= DONE;
                        end
                    end
                end
                SHIFT: begin
                    sh_q  <= step_d;
                    cnt_q <= cnt_q - 1'b1;
                    // Last bit: publish the result together with the done pulse.
                    if (cnt_q == SHW'(1)) begin
                        result_q <= step_d;
                        zero_q   <= (step_d == '0);
                        done_q   <= 1'b1;
                        state_q  <= DONE;
                    end
                end
                DONE: begin
                    done_q  <= 1'b0;
                    err_q   <= 1'b0;
                    ready_q <= 1'b1;
                    state_q <= IDLE;
                end
                default: begin
                    done_q  <= 1'b0;
                    err_q   <= 1'b0;
                    ready_q <= 1'b1;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign ready  = ready_q;
    assign done   = done_q;
    assign err    = err_q;
    assign result = result_q;
    assign zero   = zero_q;
    assign lt     = lt_q;
    assign ltu    = ltu_q;

endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq: a vector table for per-op results and latency,
// plus hand-written sequences for shift interference, reset abort and reset priority.
module tb_alu_seq;

    logic        clk;
    logic        reset;
    logic        start;
    logic [3:0]  alu_op;
    logic [31:0] operand_a;
    logic [31:0] operand_b;
    logic [31:0] pc;
    logic        ready;
    logic        done;
    logic [31:0] result;
    logic        zero;
    logic        lt;
    logic        ltu;
    logic        err;

    int total;
    int bad;

    alu_seq #(.WIDTH(32)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .alu_op    (alu_op),
        .operand_a (operand_a),
        .operand_b (operand_b),
        .pc        (pc),
        .ready     (ready),
        .done      (done),
        .result    (result),
        .zero      (zero),
        .lt        (lt),
        .ltu       (ltu),
        .err       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] pcv;
        logic [31:0] res;
        logic        z;
        logic        slt;
        logic        sltu;
        logic        e;
        int          lat;
    } vec_t;

    localparam int NV = 18;
    vec_t vecs [NV];

    function automatic vec_t mk(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                input logic [31:0] pcv, input logic [31:0] res, input logic z,
                                input logic slt, input logic sltu, input logic e, input int lat);
        vec_t v;
        v.op = op; v.a = a; v.b = b; v.pcv = pcv; v.res = res;
        v.z = z; v.slt = slt; v.sltu = sltu; v.e = e; v.lat = lat;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Issue one request and wait (bounded) for done; returns latency in cycles after acceptance.
    task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] pcv, output int lat);
        @(negedge clk);
        alu_op = op; operand_a = a; operand_b = b; pc = pcv; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        lat = 1;
        while (!done && lat < 64) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    initial begin
        int lat;
        int pulses;
        total = 0;
        bad   = 0;
        reset = 1'b1; start = 1'b0; alu_op = '0; operand_a = '0; operand_b = '0; pc = '0;

        vecs[0]  = mk(4'b0000, 32'd5,        32'd7,        32'h0,    32'd12,       1'b0, 1'b1, 1'b1, 1'b0, 1);
        vecs[1]  = mk(4'b0001, 32'd3,        32'd3,        32'h0,    32'd0,        1'b1, 1'b0, 1'b0, 1'b0, 1);
        vecs[2]  = mk(4'b0011, 32'hFFFFFFFF, 32'd1,        32'h0,    32'd1,        1'b0, 1'b1, 1'b0, 1'b0, 1);
        vecs[3]  = mk(4'b0100, 32'hFFFFFFFF, 32'd1,        32'h0,    32'd0,        1'b1, 1'b1, 1'b0, 1'b0, 1);
        vecs[4]  = mk(4'b0101, 32'h0000F0F0, 32'h0000FF00, 32'h0,    32'h00000FF0, 1'b0, 1'b1, 1'b1, 1'b0, 1);
        vecs[5]  = mk(4'b1000, 32'h0000000F, 32'h000000F0, 32'h0,    32'h000000FF, 1'b0, 1'b1, 1'b1, 1'b0, 1);
        vecs[6]  = mk(4'b1001, 32'h000000FF, 32'h0000000F, 32'h0,    32'h0000000F, 1'b0, 1'b0, 1'b0, 1'b0, 1);
        vecs[7]  = mk(4'b1010, 32'h00000123, 32'hABCDE000, 32'h0,    32'hABCDE000, 1'b0, 1'b0, 1'b1, 1'b0, 1);
        vecs[8]  = mk(4'b1011, 32'h0,        32'h2000,     32'h1000, 32'h3000,     1'b0, 1'b1, 1'b1, 1'b0, 1);
        vecs[9]  = mk(4'b0000, 32'hFFFFFFFF, 32'd1,        32'h0,    32'd0,        1'b1, 1'b1, 1'b0, 1'b0, 1);
        vecs[10] = mk(4'b0001, 32'h80000000, 32'd1,        32'h0,    32'h7FFFFFFF, 1'b0, 1'b1, 1'b0, 1'b0, 1);
        vecs[11] = mk(4'b0010, 32'd1,        32'd0,        32'h0,    32'd1,        1'b0, 1'b0, 1'b0, 1'b0, 1);
        vecs[12] = mk(4'b0111, 32'h80000000, 32'd4,        32'h0,    32'hF8000000, 1'b0, 1'b1, 1'b0, 1'b0, 5);
        vecs[13] = mk(4'b0010, 32'd1,        32'd31,       32'h0,    32'h80000000, 1'b0, 1'b1, 1'b1, 1'b0, 32);
        vecs[14] = mk(4'b0010, 32'd3,        32'd36,       32'h0,    32'h00000030, 1'b0, 1'b1, 1'b1, 1'b0, 5);
        vecs[15] = mk(4'b0110, 32'h80000000, 32'd31,       32'h0,    32'h00000001, 1'b0, 1'b1, 1'b0, 1'b0, 32);
        vecs[16] = mk(4'b1111, 32'd5,        32'd7,        32'h0,    32'd0,        1'b1, 1'b1, 1'b1, 1'b1, 1);
        vecs[17] = mk(4'b1100, 32'd0,        32'd0,        32'h0,    32'd0,        1'b1, 1'b0, 1'b0, 1'b1, 1);

        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        chk("rst_ready",  {31'd0, ready}, 32'd1);
        chk("rst_done",   {31'd0, done},  32'd0);
        chk("rst_result", result,         32'd0);
        chk("rst_zero",   {31'd0, zero},  32'd1);
        chk("rst_lt",     {30'd0, lt, ltu}, 32'd0);
        chk("rst_err",    {31'd0, err},   32'd0);

        for (int i = 0; i < NV; i++) begin
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].pcv, lat);
            chk($sformatf("v%0d_lat", i),    lat,                vecs[i].lat);
            chk($sformatf("v%0d_result", i), result,             vecs[i].res);
            chk($sformatf("v%0d_zero", i),   {31'd0, zero},      {31'd0, vecs[i].z});
            chk($sformatf("v%0d_lt", i),     {31'd0, lt},        {31'd0, vecs[i].slt});
            chk($sformatf("v%0d_ltu", i),    {31'd0, ltu},       {31'd0, vecs[i].sltu});
            chk($sformatf("v%0d_err", i),    {31'd0, err},       {31'd0, vecs[i].e});
            chk($sformatf("v%0d_ready", i),  {31'd0, ready},     32'd0);
            @(posedge clk);
            #1;
            chk($sformatf("v%0d_pulse", i),  {30'd0, done, err}, 32'd0);
            chk($sformatf("v%0d_idle", i),   {31'd0, ready},     32'd1);
            chk($sformatf("v%0d_hold", i),   result,             vecs[i].res);
        end

        // SRL with operand_a changed and start re-asserted while shifting.
        @(negedge clk);
        alu_op = 4'b0110; operand_a = 32'h000000F0; operand_b = 32'd4; start = 1'b1;
        @(posedge clk);
        #1;
        operand_a = 32'h12345678;
        lat = 1;
        pulses = 0;
        while (!done && lat < 64) begin
            @(posedge clk);
            #1;
            lat++;
        end
        start = 1'b0;
        chk("srl_lat",    lat,    5);
        chk("srl_result", result, 32'h0000000F);
        for (int c = 0; c < 8; c++) begin
            @(posedge clk);
            #1;
            if (done) pulses++;
        end
        chk("srl_single_done", pulses, 0);
        chk("srl_hold", result, 32'h0000000F);

        // Reset in the second SHIFT cycle of SLL by 8 aborts the operation.
        @(negedge clk);
        alu_op = 4'b0010; operand_a = 32'd1; operand_b = 32'd8; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        chk("abort_ready",  {31'd0, ready}, 32'd1);
        chk("abort_result", result,         32'd0);
        chk("abort_zero",   {31'd0, zero},  32'd1);
        pulses = 0;
        for (int c = 0; c < 12; c++) begin
            if (done) pulses++;
            @(posedge clk);
            #1;
        end
        chk("abort_no_done", pulses, 0);
        run_op(4'b1011, 32'h0, 32'h2000, 32'h1000, lat);
        chk("auipc_lat",    lat,    1);
        chk("auipc_result", result, 32'h3000);

        // Reset wins over a simultaneous start.
        @(negedge clk);
        alu_op = 4'b0000; operand_a = 32'd9; operand_b = 32'd9; start = 1'b1; reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0; start = 1'b0;
        chk("rststart_ready",  {31'd0, ready}, 32'd1);
        chk("rststart_done",   {31'd0, done},  32'd0);
        @(posedge clk);
        #1;
        chk("rststart_done2",  {31'd0, done},  32'd0);
        chk("rststart_result", result,         32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/alu_seq.md
ALU_SEQ -- requirements
Module: alu_seq

Interface
REQ-001 Parameter: WIDTH, 32, datapath width; shift amount = operand_b[$clog2(WIDTH)-1:0].
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 start  input  1  request; accepted only on a rising edge where start=1 and ready=1.
REQ-005 alu_op  input  4  operation code, produced by alu_control.
REQ-006 operand_a  input  WIDTH  first operand (rs1).
REQ-007 operand_b  input  WIDTH  second operand (rs2, immediate, or upper immediate).
REQ-008 pc  input  WIDTH  program counter, used only by AUIPC.
REQ-009 ready  output  1  block idle and able to accept start.
REQ-010 done  output  1  one-cycle pulse; result and flags valid.
REQ-011 result  output  WIDTH  registered result.
REQ-012 zero  output  1  result == 0.
REQ-013 lt  output  1  signed operand_a < operand_b, latched operands.
REQ-014 ltu  output  1  unsigned operand_a < operand_b, latched operands.
REQ-015 err  output  1  pulses with done when alu_op is undefined.

Function
REQ-016 Encodings: ADD 0000, SUB 0001, SLL 0010, SLT 0011, SLTU 0100, XOR 0101, SRL 0110, SRA 0111, OR 1000, AND 1001, LUI 1010, AUIPC 1011; 1100-1111 undefined.
REQ-017 On acceptance, alu_op, operand_a, operand_b, pc SHALL be latched; input changes after acceptance have no effect.
REQ-018 FSM states: IDLE, SHIFT, DONE; ready=1 only in IDLE, done=1 only in DONE.
REQ-019 IDLE -> SHIFT on acceptance of SLL/SRL/SRA with shamt>0, shift counter loaded with shamt.
REQ-020 IDLE -> DONE on acceptance of any other op or a shift with shamt=0; result computed combinationally from latched-at-edge inputs and registered.
REQ-021 SHIFT: one bit per cycle (SLL zero-fill left, SRL zero-fill right, SRA sign-fill right), counter decrements; transition to DONE on the cycle the counter reaches 1.
REQ-022 DONE -> IDLE unconditionally after one cycle; start during DONE or SHIFT is ignored (not queued).
REQ-023 Latency: acceptance at edge k -> done in cycle k+1 for non-shift/shamt=0; done in cycle k+1+shamt for shifts.
REQ-024 Arithmetic modulo 2^WIDTH; ADD/SUB/AUIPC carry and overflow discarded; SLT/SLTU result = {WIDTH-1 zeros, flag}.
REQ-025 LUI: result = operand_b; AUIPC: result = pc + operand_b.
REQ-026 Undefined alu_op: result = 0, err=1 in the DONE cycle, 1-cycle latency.
REQ-027 result, zero, lt, ltu SHALL hold their values from the DONE cycle until the next acceptance.
REQ-028 zero, lt, ltu SHALL be valid for every op (branch compares use SUB with these flags).

Reset
REQ-029 reset=1 at an edge forces IDLE, result=0, zero=1, lt=0, ltu=0, done=0, err=0, counter=0; ready=1 in the following cycle.
REQ-030 reset overrides start in the same cycle; no request accepted while reset=1.
REQ-031 reset during SHIFT or DONE aborts the operation; no done pulse is produced for it.

Verification
REQ-032 ADD a=5, b=7, start one cycle -> done next cycle, result=12, zero=0, ready low exactly 1 cycle.
REQ-033 SUB a=3, b=3 -> result=0, zero=1; SLT a=0xFFFFFFFF, b=1 -> result=1, lt=1; SLTU same operands -> result=0, ltu=0.
REQ-034 SRA a=0x80000000, b=4 -> done 5 cycles after acceptance, result=0xF8000000; SLL a=0x1, b=0 -> done next cycle, result=0x1.
REQ-035 SRL a=0xF0, b=4 accepted, then operand_a changed and start re-asserted during SHIFT -> second start ignored, result=0x0F, single done pulse.
REQ-036 Reset asserted in 2nd SHIFT cycle of SLL by 8 -> next cycle ready=1, result=0, no done pulse; AUIPC pc=0x1000, b=0x2000 afterwards -> result=0x3000.
REQ-037 alu_op=1111 -> done and err both pulse next cycle, result=0, zero=1.
